cnn_param_streamer: RTL

Host-side streamer that serves the CNN accelerator's parameter-load handshake. It watches the seven load-request flags: conv_weight1/2/3, fc_weight1/2, img_input and right_answer. For each request it reads the matching region from a flat parameter memory and drives ex_data/ex_addr/ex_we word by word. After the last word it pulses the matching done_* line. It also issues the one-cycle srt pulse that starts a learning run.

---
 rtl/cnn_param_streamer_pkg.sv | 48 ++++
 rtl/cnn_param_streamer_if.sv | 49 ++++
 rtl/cnn_param_streamer_region_sel.sv | 45 ++++
 rtl/cnn_param_streamer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cnn_param_streamer_pkg.sv
// Shared types and memory-layout constants for the CNN parameter streamer.
// Region bases are cumulative sums of the region lengths.
package cnn_param_pkg;

    localparam int CONV_LEN = 9;
    localparam int FC1_LEN  = 640;
    localparam int FC2_LEN  = 200;
    localparam int IMG_LEN  = 324;
    localparam int ANS_LEN  = 10;

    localparam int CONV1_BASE  = 0;
    localparam int CONV2_BASE  = CONV1_BASE + CONV_LEN;
    localparam int CONV3_BASE  = CONV2_BASE + CONV_LEN;
    localparam int FC1_BASE    = CONV3_BASE + CONV_LEN;
    localparam int FC2_BASE    = FC1_BASE + FC1_LEN;
    localparam int IMG_BASE    = FC2_BASE + FC2_LEN;
    localparam int ANS_BASE    = IMG_BASE + IMG_LEN;
    localparam int TOTAL_WORDS = ANS_BASE + ANS_LEN;

    localparam int NUM_REGIONS = 7;
    localparam int CNT_W       = $clog2(FC1_LEN) + 1;
    localparam int BASE_W      = $clog2(TOTAL_WORDS);

    // Encoding order is the service priority: lower value wins.
    typedef enum logic [2:0] {
        RG_CONV1 = 3'd0,
        RG_CONV2 = 3'd1,
        RG_CONV3 = 3'd2,
        RG_FC1   = 3'd3,
        RG_FC2   = 3'd4,
        RG_IMG   = 3'd5,
        RG_ANS   = 3'd6
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STREAM  = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // True when the whole parameter image is addressable with src_aw bits.
    function automatic bit src_layout_fits(input int src_aw);
        return TOTAL_WORDS <= (1 << src_aw);
    endfunction

endpackage

// File: rtl/cnn_param_streamer_if.sv
// Load-request / parameter-write bundle between the host streamer (master)
// and the accelerator controller plus parameter memory (slave).
interface cnn_param_streamer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int SRC_AW = 11
);
    logic              go;
    logic              conv_weight1;
    logic              conv_weight2;
    logic              conv_weight3;
    logic              fc_weight1;
    logic              fc_weight2;
    logic              img_input;
    logic              right_answer;
    logic [DATA_W-1:0] src_data;

    logic              srt;
    logic              src_rd;
    logic [SRC_AW-1:0] src_addr;
    logic [DATA_W-1:0] ex_data;
    logic [ADDR_W-1:0] ex_addr;
    logic              ex_we;
    logic              done_conv_weight1;
    logic              done_conv_weight2;
    logic              done_conv_weight3;
    logic              done_fc_weight1;
    logic              done_fc_weight2;
    logic              done_img_input;
    logic              done_right_answer;

    modport master (
        input  go, conv_weight1, conv_weight2, conv_weight3, fc_weight1,
               fc_weight2, img_input, right_answer, src_data,
        output srt, src_rd, src_addr, ex_data, ex_addr, ex_we,
               done_conv_weight1, done_conv_weight2, done_conv_weight3,
               done_fc_weight1, done_fc_weight2, done_img_input,
               done_right_answer
    );

    modport slave (
        output go, conv_weight1, conv_weight2, conv_weight3, fc_weight1,
               fc_weight2, img_input, right_answer, src_data,
        input  srt, src_rd, src_addr, ex_data, ex_addr, ex_we,
               done_conv_weight1, done_conv_weight2, done_conv_weight3,
               done_fc_weight1, done_fc_weight2, done_img_input,
               done_right_answer
    );
endinterface

// File: rtl/cnn_param_streamer_region_sel.sv
// Combinational region lookup: priority-encodes the live requests and maps
// the latched region to its memory base, length and done one-hot.
module param_region_sel
    import cnn_param_pkg::*;
(
    input  logic [NUM_REGIONS-1:0] req,
    input  region_e                lat_region,
    output logic                   any_req,
    output region_e                pri_region,
    output logic [BASE_W-1:0]      lat_base,
    output logic [CNT_W-1:0]       lat_len,
    output logic [NUM_REGIONS-1:0] lat_done
);

    assign any_req = |req;

    // Scan from lowest priority upward so the highest-priority hit lands last.
    always_comb begin
        pri_region = RG_CONV1;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (req[i]) pri_region = region_e'(3'(i));
        end
    end

    always_comb begin
        lat_base = BASE_W'(CONV1_BASE);
        lat_len  = CNT_W'(CONV_LEN);
        case (lat_region)
            RG_CONV1: begin lat_base = BASE_W'(CONV1_BASE); lat_len = CNT_W'(CONV_LEN); end
            RG_CONV2: begin lat_base = BASE_W'(CONV2_BASE); lat_len = CNT_W'(CONV_LEN); end
            RG_CONV3: begin lat_base = BASE_W'(CONV3_BASE); lat_len = CNT_W'(CONV_LEN); end
            RG_FC1:   begin lat_base = BASE_W'(FC1_BASE);   lat_len = CNT_W'(FC1_LEN);  end
            RG_FC2:   begin lat_base = BASE_W'(FC2_BASE);   lat_len = CNT_W'(FC2_LEN);  end
            RG_IMG:   begin lat_base = BASE_W'(IMG_BASE);   lat_len = CNT_W'(IMG_LEN);  end
            RG_ANS:   begin lat_base = BASE_W'(ANS_BASE);   lat_len = CNT_W'(ANS_LEN);  end
            default:  begin lat_base = BASE_W'(CONV1_BASE); lat_len = CNT_W'(CONV_LEN); end
        endcase
    end

    always_comb begin
        lat_done             = '0;
        lat_done[lat_region] = 1'b1;
    end

endmodule

// File: rtl/cnn_param_streamer.sv
// Host-side parameter streamer: serves one load request at a time by reading
// its memory region and writing it word by word through a 2-stage pipe.
module cnn_param_streamer
    import cnn_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int SRC_AW = 11
) (
    input logic                  clk,
    input logic                  reset,
    cnn_param_streamer_if.master bus
);

    if (!src_layout_fits(SRC_AW)) begin : g_src_aw_check
        $error("parameter memory layout exceeds SRC_AW address space");
    end

    logic [NUM_REGIONS-1:0] req;
    assign req = {bus.right_answer, bus.img_input, bus.fc_weight2, bus.fc_weight1,
                  bus.conv_weight3, bus.conv_weight2, bus.conv_weight1};

    state_e                 state, state_nx;
    region_e                lat_region, pri_region;
    logic                   any_req;
    logic [BASE_W-1:0]      lat_base;
    logic [CNT_W-1:0]       lat_len;
    logic [NUM_REGIONS-1:0] lat_done;
    logic [CNT_W-1:0]       rd_cnt;
    logic                   req_lat, abort, last_rd;
    logic [SRC_AW-1:0]      rd_addr;

    logic                   srt_d, src_rd_d, latch_en, cnt_inc;
    logic [NUM_REGIONS-1:0] done_d;

    logic                   srt_q, src_rd_q;
    logic [SRC_AW-1:0]      src_addr_q;
    logic [NUM_REGIONS-1:0] done_q;
    logic [CNT_W-1:0]       idx_rd;
    logic                   vld_p0, vld_p1;
    logic [CNT_W-1:0]       idx_p0, idx_p1;
    logic [DATA_W-1:0]      data_p1;

    param_region_sel u_region_sel (
        .req        (req),
        .lat_region (lat_region),
        .any_req    (any_req),
        .pri_region (pri_region),
        .lat_base   (lat_base),
        .lat_len    (lat_len),
        .lat_done   (lat_done)
    );

    assign req_lat = req[lat_region];
    assign abort   = ((state == ST_STREAM) || (state == ST_FLUSH)) && !req_lat;
    assign last_rd = (rd_cnt == (lat_len - CNT_W'(1)));
    assign rd_addr = SRC_AW'({1'b0, lat_base} + (BASE_W + 1)'(rd_cnt));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (any_req) state_nx = ST_STREAM;
            ST_STREAM:  if (!req_lat) state_nx = ST_IDLE;
                        else if (last_rd) state_nx = ST_FLUSH;
            // Leave once the final read has left the issue register.
            ST_FLUSH:   if (!req_lat) state_nx = ST_IDLE;
                        else if (!src_rd_q) state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_RELEASE;
            ST_RELEASE: if (!req_lat) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        srt_d    = 1'b0;
        src_rd_d = 1'b0;
        latch_en = 1'b0;
        cnt_inc  = 1'b0;
        done_d   = '0;
        case (state)
            ST_IDLE:   if (any_req) latch_en = 1'b1;
                       else srt_d = bus.go;
            ST_STREAM: if (req_lat) begin
                           src_rd_d = 1'b1;
                           cnt_inc  = 1'b1;
                       end
            ST_DONE:   done_d = lat_done;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_region <= RG_CONV1;
            rd_cnt     <= '0;
            srt_q      <= 1'b0;
            src_rd_q   <= 1'b0;
            src_addr_q <= '0;
            done_q     <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            idx_p1     <= '0;
            data_p1    <= '0;
        end else begin
            srt_q    <= srt_d;
            src_rd_q <= src_rd_d;
            done_q   <= done_d;
            if (latch_en) begin
                lat_region <= pri_region;
                rd_cnt     <= '0;
            end else if (cnt_inc) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (src_rd_d) src_addr_q <= rd_addr;
            // Stage 1: issued read becomes a pending write slot.
            vld_p0 <= src_rd_q && !abort;
            // Stage 2: returned memory word is registered onto the write port.
            vld_p1 <= vld_p0 && !abort;
            if (vld_p0 && !abort) begin
                idx_p1  <= idx_p0;
                data_p1 <= bus.src_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_rd <= rd_cnt;
        idx_p0 <= idx_rd;
    end

    assign bus.srt               = srt_q;
    assign bus.src_rd            = src_rd_q;
    assign bus.src_addr          = src_addr_q;
    assign bus.ex_we             = vld_p1;
    assign bus.ex_addr           = ADDR_W'(idx_p1);
    assign bus.ex_data           = data_p1;
    assign bus.done_conv_weight1 = done_q[0];
    assign bus.done_conv_weight2 = done_q[1];
    assign bus.done_conv_weight3 = done_q[2];
    assign bus.done_fc_weight1   = done_q[3];
    assign bus.done_fc_weight2   = done_q[4];
    assign bus.done_img_input    = done_q[5];
    assign bus.done_right_answer = done_q[6];

endmodule
